// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, digit constants and digit-edit helpers for the clock time setter
//
// State encoding doubles as the value driven on the 'selected' output.
// Digit indices follow the BCD packing {h10,h1,m10,m1,s10,s1}, so digit i
// lives in bits [4*i+3:4*i] and blank_mask bit i blanks it.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_NONE  = 3'd0,
        ST_SEC   = 3'd1,
        ST_SEC10 = 3'd2,
        ST_MIN   = 3'd3,
        ST_MIN10 = 3'd4,
        ST_HR    = 3'd5,
        ST_HR10  = 3'd6
    } sel_state_t;

    localparam logic [2:0] DIGIT_S1   = 3'd0;
    localparam logic [2:0] DIGIT_S10  = 3'd1;
    localparam logic [2:0] DIGIT_M1   = 3'd2;
    localparam logic [2:0] DIGIT_M10  = 3'd3;
    localparam logic [2:0] DIGIT_H1   = 3'd4;
    localparam logic [2:0] DIGIT_H10  = 3'd5;
    localparam logic [2:0] DIGIT_NONE = 3'd7;

    localparam logic [3:0] MAX_S1       = 4'd9;
    localparam logic [3:0] MAX_S10      = 4'd5;
    localparam logic [3:0] MAX_M1       = 4'd9;
    localparam logic [3:0] MAX_M10      = 4'd5;
    localparam logic [3:0] MAX_H1       = 4'd9;
    localparam logic [3:0] MAX_H1_AT_20 = 4'd3;
    localparam logic [3:0] MAX_H10      = 4'd2;

    // Select key walks the digits from seconds up to tens-of-hours, then exits.
    // Any code outside the enum falls back to NONE.
    function automatic sel_state_t next_state(input sel_state_t s);
        case (s)
            ST_NONE:  return ST_SEC;
            ST_SEC:   return ST_SEC10;
            ST_SEC10: return ST_MIN;
            ST_MIN:   return ST_MIN10;
            ST_MIN10: return ST_HR;
            ST_HR:    return ST_HR10;
            default:  return ST_NONE;
        endcase
    endfunction

    function automatic logic [2:0] digit_of(input sel_state_t s);
        case (s)
            ST_SEC:   return DIGIT_S1;
            ST_SEC10: return DIGIT_S10;
            ST_MIN:   return DIGIT_M1;
            ST_MIN10: return DIGIT_M10;
            ST_HR:    return DIGIT_H1;
            ST_HR10:  return DIGIT_H10;
            default:  return DIGIT_NONE;
        endcase
    endfunction

    // One-hot blank bit for a digit; DIGIT_NONE shifts out to all-zero.
    function automatic logic [5:0] digit_mask(input logic [2:0] idx);
        return 6'b00_0001 << idx;
    endfunction

    // '>=' rather than '==' so an out-of-range digit loaded from time_in
    // still wraps back to zero instead of counting up through 15.
    function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    // Increment one digit with wrap and no carry into its neighbour.
    function automatic logic [23:0] advance_digit(input logic [23:0] t, input logic [2:0] idx);
        logic [23:0] r;
        r = t;
        case (idx)
            DIGIT_S1:  r[3:0]   = wrap_inc(t[3:0],   MAX_S1);
            DIGIT_S10: r[7:4]   = wrap_inc(t[7:4],   MAX_S10);
            DIGIT_M1:  r[11:8]  = wrap_inc(t[11:8],  MAX_M1);
            DIGIT_M10: r[15:12] = wrap_inc(t[15:12], MAX_M10);
            DIGIT_H1:  r[19:16] = wrap_inc(t[19:16],
                                           (t[23:20] == MAX_H10) ? MAX_H1_AT_20 : MAX_H1);
            DIGIT_H10: begin
                r[23:20] = wrap_inc(t[23:20], MAX_H10);
                // Entering the 20s with h1 above 3 would form an invalid hour.
                if (r[23:20] == MAX_H10 && t[19:16] > MAX_H1_AT_20) begin
                    r[19:16] = 4'd0;
                end
            end
            default: r = t;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronizer, debouncer and press-edge detector for one active-low key
//
// Ports:
//   clk    - sampling clock
//   rst    - asynchronous active-high reset; debounced level starts released (high)
//   key_n  - raw active-low key, asynchronous to clk
//   press  - one-cycle pulse when the debounced level falls; release gives nothing
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q2;
                cnt    <= '0;
                // Old level high means this acceptance is the falling edge.
                press  <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - two-key BCD time editor with digit blink and load strobe
//
// Optional feature: SETTER_TIMEOUT_EN adds an idle timer that abandons an
// edit (back to NONE, no load) after TIMEOUT_CYCLES without a key event.
//
// Ports:
//   CLOCK_50   - sole clock
//   reset      - asynchronous active-high reset
//   select_n   - raw active-low select key
//   advance_n  - raw active-low advance key
//   time_in    - current BCD time {h10,h1,m10,m1,s10,s1}
//   time_out   - edited BCD time (shadow register)
//   load       - one-cycle strobe after leaving tens-of-hours
//   selected   - current state code
//   setting    - high while editing
//   blank_mask - per-digit blank, bit 0 = s1
module clock_time_setter
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        select_n,
    input  logic        advance_n,
    input  logic [23:0] time_in,
    output logic [23:0] time_out,
    output logic        load,
    output logic [2:0]  selected,
    output logic        setting,
    output logic [5:0]  blank_mask
);

    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic               select_evt;
    logic               advance_evt;
    logic               abort;
    sel_state_t         state;
    sel_state_t         state_nx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select_key (
        .clk   (CLOCK_50),
        .rst   (reset),
        .key_n (select_n),
        .press (select_evt)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_advance_key (
        .clk   (CLOCK_50),
        .rst   (reset),
        .key_n (advance_n),
        .press (advance_evt)
    );

`ifdef SETTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state == ST_NONE || select_evt || advance_evt) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Fires on the last idle cycle of the window; a key event in that same
    // cycle still counts as activity.
    assign abort = (state != ST_NONE) && !select_evt && !advance_evt && (idle_cnt == TO_LAST);
`else
    assign abort = 1'b0;

    // Idle window unused in this build; block kept so the parameter is consumed.
    if (TIMEOUT_CYCLES == 0) begin : g_no_idle_window
    end
`endif

    // Select wins over both advance and the idle abort.
    always_comb begin
        state_nx = state;
        if (select_evt) begin
            state_nx = next_state(state);
        end else if (abort) begin
            state_nx = ST_NONE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= ST_NONE;
            load         <= 1'b0;
            setting      <= 1'b0;
            time_out     <= '0;
            blank_mask   <= '0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else begin
            state   <= state_nx;
            setting <= (state_nx != ST_NONE);
            load    <= select_evt && (state == ST_HR10);

            if (select_evt) begin
                if (state == ST_NONE) begin
                    time_out <= time_in;
                end
            end else if (advance_evt && state != ST_NONE) begin
                time_out <= advance_digit(time_out, digit_of(state));
            end

            // Blink restarts visible on every state change and idles in NONE.
            if (state_nx != state || state_nx == ST_NONE) begin
                blink_cnt    <= '0;
                blink_hidden <= 1'b0;
                blank_mask   <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                blink_hidden <= !blink_hidden;
                blank_mask   <= blink_hidden ? 6'd0 : digit_mask(digit_of(state));
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign selected = state;

endmodule

// File: tb/tb_clock_time_setter.sv
// tb/tb_clock_time_setter.sv - self-checking bench for clock_time_setter
module tb_clock_time_setter;

    localparam int unsigned DEB   = 4;
    localparam int unsigned BLINK = 8;
    localparam int unsigned TMO   = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select_n = 1'b1;
    logic        advance_n = 1'b1;
    logic [23:0] time_in = 24'h0;
    logic [23:0] time_out;
    logic        load;
    logic [2:0]  selected;
    logic        setting;
    logic [5:0]  blank_mask;

    always #5 clk = ~clk;

    clock_time_setter #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_CYCLES    (BLINK),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .select_n   (select_n),
        .advance_n  (advance_n),
        .time_in    (time_in),
        .time_out   (time_out),
        .load       (load),
        .selected   (selected),
        .setting    (setting),
        .blank_mask (blank_mask)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edit position 0..6 and six decimal digits.
    int          m_state = 0;
    int          m_dig [6];
    int          m_loads = 0;
    logic [23:0] m_load_val = 24'h0;

    // Observed load strobes.
    int          obs_loads = 0;
    int          obs_wide = 0;
    logic [23:0] obs_load_val = 24'h0;
    logic [2:0]  obs_load_sel = 3'd0;
    logic [2:0]  obs_load_prev_sel = 3'd0;
    logic [2:0]  prev_sel = 3'd0;
    logic        prev_load = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (load === 1'b1) begin
            obs_loads++;
            obs_load_val      = time_out;
            obs_load_sel      = selected;
            obs_load_prev_sel = prev_sel;
            if (prev_load === 1'b1) obs_wide++;
        end
        prev_sel  = selected;
        prev_load = load;
    endtask

    function automatic logic [23:0] m_pack();
        logic [23:0] r;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    function automatic logic [23:0] rand_time();
        int h, m, s;
        h = int'($urandom_range(23));
        m = int'($urandom_range(59));
        s = int'($urandom_range(59));
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_select();
        if (m_state == 0) begin
            for (int i = 0; i < 6; i++) m_dig[i] = int'(time_in[4*i +: 4]);
        end else if (m_state == 6) begin
            m_loads++;
            m_load_val = m_pack();
        end
        m_state = (m_state == 6) ? 0 : m_state + 1;
    endtask

    task automatic model_advance();
        int idx, lim;
        if (m_state == 0) return;
        idx = m_state - 1;
        case (idx)
            0, 2:    lim = 9;
            1, 3:    lim = 5;
            4:       lim = (m_dig[5] == 2) ? 3 : 9;
            default: lim = 2;
        endcase
        m_dig[idx] = (m_dig[idx] >= lim) ? 0 : m_dig[idx] + 1;
        if (idx == 5 && m_dig[5] == 2 && m_dig[4] > 3) m_dig[4] = 0;
    endtask

    task automatic press(input bit sel, input bit adv, input int hold, input int rel);
        select_n  = !sel;
        advance_n = !adv;
        repeat (hold) tick();
        select_n  = 1'b1;
        advance_n = 1'b1;
        repeat (rel) tick();
        if (sel) model_select();
        else if (adv) model_advance();
    endtask

    task automatic check_outputs(input string tag);
        logic ok_blank;
        check({tag, "/selected"}, selected, m_state);
        check({tag, "/setting"}, setting, (m_state != 0));
        check({tag, "/time_out"}, time_out, m_pack());
        check({tag, "/loads"}, obs_loads, m_loads);
        ok_blank = (blank_mask === 6'd0) ||
                   (m_state != 0 && blank_mask === 6'(1 << (m_state - 1)));
        check({tag, "/blank_mask"}, ok_blank, 1'b1);
        if (m_loads > 0) begin
            check({tag, "/load_val"}, obs_load_val, m_load_val);
            check({tag, "/load_sel"}, obs_load_sel, 3'd0);
            check({tag, "/load_prev_sel"}, obs_load_prev_sel, 3'd6);
            check({tag, "/load_width"}, obs_wide, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, vis, hid, bad, loads_before;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;

        // Reset state
        repeat (3) tick();
        check("rst/selected", selected, 3'd0);
        check("rst/setting", setting, 1'b0);
        check("rst/load", load, 1'b0);
        check("rst/blank", blank_mask, 6'd0);
        check("rst/time_out", time_out, 24'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Bouncing select key must not register
        time_in = 24'h235959;
        repeat (3) begin
            select_n = 1'b0; repeat (3) tick();
            select_n = 1'b1; repeat (3) tick();
        end
        repeat (6) tick();
        check("glitch/selected", selected, 3'd0);
        check("glitch/time_out", time_out, 24'h0);

        // Held press -> exactly one event
        press(1, 0, 6, 8);
        check("hold/selected", selected, 3'd1);
        check("hold/time_out", time_out, 24'h235959);
        check_outputs("hold");

        // s1 wraps 9->0 without carry
        press(0, 1, 6, 8);
        check("s1wrap/time_out", time_out, 24'h235950);
        check_outputs("s1wrap");

        // Walk out of the edit: load after the 7th select
        repeat (6) press(1, 0, 6, 8);
        check("exit/loads", obs_loads, 1);
        check("exit/load_val", obs_load_val, 24'h235950);
        check_outputs("exit");

        // h10 1->2 forces h1 from 9 to 0, then 2->0
        time_in = 24'h195000;
        repeat (6) press(1, 0, 6, 8);
        check("hr10/selected", selected, 3'd6);
        press(0, 1, 6, 8);
        check("hr10/adv1", time_out, 24'h205000);
        press(0, 1, 7, 9);
        check("hr10/adv2", time_out, 24'h005000);
        press(1, 0, 6, 8);
        check("hr10/load_val", obs_load_val, 24'h005000);
        check_outputs("hr10");

        // Simultaneous select+advance in MIN: select wins
        time_in = rand_time();
        repeat (3) press(1, 0, 6, 8);
        check("simul/in_min", selected, 3'd3);
        press(1, 1, 6, 8);
        check("simul/selected", selected, 3'd4);
        check("simul/m1", time_out[11:8], time_in[11:8]);
        check_outputs("simul");
        repeat (3) press(1, 0, 6, 8);
        check_outputs("simul_exit");

        // Blink restarts visible on state entry, then toggles every BLINK cycles
        time_in = rand_time();
        check("blink/none", blank_mask, 6'd0);
        select_n = 1'b0;
        waited = 0;
        while (selected === 3'd0 && waited < 20) begin
            tick();
            waited++;
        end
        check("blink/enter", selected, 3'd1);
        vis = 0;
        for (int i = 0; i < 8; i++) begin
            if (blank_mask === 6'd0) vis++;
            tick();
        end
        check("blink/visible_run", vis, 8);
        check("blink/first_hide", blank_mask, 6'b000001);
        hid = 0;
        bad = 0;
        repeat (32) begin
            tick();
            if (blank_mask === 6'b000001) hid++;
            else if (blank_mask !== 6'd0) bad++;
        end
        check("blink/hidden_count", hid, 16);
        check("blink/other_bits", bad, 0);
        select_n = 1'b1;
        repeat (8) tick();
        model_select();
        check_outputs("blink");
        repeat (6) press(1, 0, 6, 8);
        check_outputs("blink_exit");

        // Reset while in HR: immediate clear, no load
        time_in = rand_time();
        repeat (5) press(1, 0, 6, 8);
        check("rst_hr/in_hr", selected, 3'd5);
        loads_before = obs_loads;
        reset = 1'b1;
        #1;
        check("rst_hr/selected", selected, 3'd0);
        check("rst_hr/setting", setting, 1'b0);
        check("rst_hr/load", load, 1'b0);
        check("rst_hr/blank", blank_mask, 6'd0);
        check("rst_hr/time_out", time_out, 24'h0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_hr/no_load", obs_loads, loads_before);
        m_state = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
        check_outputs("rst_hr");

`ifdef SETTER_TIMEOUT_EN
        // Idle in MIN past the timeout: abort without load
        time_in = rand_time();
        repeat (3) press(1, 0, 6, 8);
        check("tmo/in_min", selected, 3'd3);
        loads_before = obs_loads;
        repeat (110) tick();
        check("tmo/selected", selected, 3'd0);
        check("tmo/no_load", obs_loads, loads_before);
        m_state = 0;
        check_outputs("tmo");
`endif

        // Randomized key sequence against the model
        for (int it = 0; it < 40; it++) begin
            int op;
            time_in = rand_time();
            op = int'($urandom_range(4));
            case (op)
                0, 1:    press(1, 0, int'($urandom_range(6, 9)), int'($urandom_range(7, 10)));
                2, 3:    press(0, 1, int'($urandom_range(6, 9)), int'($urandom_range(7, 10)));
                default: press(1, 1, int'($urandom_range(6, 9)), int'($urandom_range(7, 10)));
            endcase
            check_outputs($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_time_setter.md
CLOCK_TIME_SETTER -- requirements
Module: clock_time_setter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning clock cycles a key must hold stable before a level change is accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 12_500_000, meaning half-period of the blink toggle for the selected digit.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000, meaning idle cycles before auto-abort (used only under REQ-027).
REQ-004 CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 select_n  input  1  raw active-low select key, asynchronous to CLOCK_50.
REQ-007 advance_n  input  1  raw active-low advance key, asynchronous to CLOCK_50.
REQ-008 time_in  input  24  current BCD time {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
REQ-009 time_out  output  24  edited BCD time, same packing as time_in.
REQ-010 load  output  1  one-cycle strobe; time_out is valid while load is high.
REQ-011 selected  output  3  current state code (0 NONE, 1 SEC, 2 SECx10, 3 MIN, 4 MINx10, 5 HR, 6 HRx10).
REQ-012 setting  output  1  high whenever selected != NONE.
REQ-013 blank_mask  output  6  bit i high blanks display digit i (bit 0 = s1).

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-015 A press event SHALL be a single-cycle pulse on the debounced high-to-low transition; release SHALL produce no event.
REQ-016 On a select event the FSM SHALL advance NONE->SEC->SECx10->MIN->MINx10->HR->HRx10->NONE; undefined codes SHALL go to NONE.
REQ-017 On NONE->SEC the block SHALL copy time_in into the shadow register driving time_out, in the same cycle.
REQ-018 On an advance event in a non-NONE state the selected digit SHALL increment by 1 with wrap, without carry: s1 9->0, s10 5->0, m1 9->0, m10 5->0, h10 2->0, h1 9->0 when h10<2, h1 3->0 when h10==2.
REQ-019 When h10 steps 1->2 while h1>3, h1 SHALL be forced to 0 in the same cycle.
REQ-020 Advance events in NONE SHALL be ignored.
REQ-021 On HRx10->NONE, load SHALL pulse high for exactly the following cycle, with time_out holding the shadow value.
REQ-022 Simultaneous select and advance events in one cycle: select SHALL take effect and advance SHALL be dropped.
REQ-023 blank_mask SHALL be all-zero in NONE; otherwise only the selected digit's bit SHALL follow the blink toggle, which restarts at "visible" on every state change.
REQ-024 Outside load cycles time_out SHALL hold its last value, and load SHALL never assert other than per REQ-021.

Reset
REQ-025 On reset assertion, immediately: state NONE, load 0, setting 0, blank_mask 0, time_out 0, debouncers at released level, blink and timeout counters 0.
REQ-026 Reset mid-edit SHALL discard the shadow and produce no load pulse.

Configuration
REQ-027 With SETTER_TIMEOUT_EN defined, TIMEOUT_CYCLES without any key event in a non-NONE state SHALL return the FSM to NONE with no load (abort); without the macro the FSM SHALL remain in its state indefinitely and no timeout counter SHALL exist.

Structure
REQ-028 A shared package clock_pkg SHALL hold the state encoding type, per-digit maximum constants (9,5,9,5,9/3,2), and the digit index constants.
REQ-029 Debounce and edge detection SHALL be one sub-module, key_debouncer, instantiated once per key.

Verification
REQ-030 DEBOUNCE_CYCLES=4: select_n bouncing with 3-cycle glitches -> no select event; held low 6 cycles -> exactly one event, selected=1.
REQ-031 time_in=0x235959, select once, advance once -> time_out=0x235950 (s1 9->0, no carry into s10).
REQ-032 time_in=0x195000, navigate to HRx10, advance -> time_out=0x205000 (h1 9 forced to 0); advance again -> 0x005000.
REQ-033 Seven select events from NONE -> load high exactly one cycle after the 7th, time_out equals edited shadow, selected=0.
REQ-034 Select and advance pulses in the same cycle while in MIN -> selected=4, m1 unchanged.
REQ-035 Reset asserted while in HR -> outputs per REQ-025 at once, load never pulses; with SETTER_TIMEOUT_EN and TIMEOUT_CYCLES=100, idle 100 cycles in MIN -> selected=0, no load.
